// File: rtl/video_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_monitor
// Purpose  : Measures the raster geometry of an incoming video stream
//            (h_total, h_active, v_total, v_active), declares lock after a
//            run of identical frames, and reports through a small register
//            file. It flags loss of lock as sticky "unstable" and loss of
//            VS as "timeout".
// Config   : Define VIDEO_MON_CHECKSUM_EN to build the per-frame pixel
//            checksum (register 4). Without it register 4 reads 0 and no
//            checksum logic is built.
// Ports    : clk_core_12288  - pixel clock, the only clock
//            reset_n         - asynchronous active-low reset
//            video_rgb[23:0] - pixel data
//            video_de        - active pixel qualifier
//            video_vs        - frame-start pulse
//            video_hs        - line-start pulse
//            rd, rd_addr     - one-cycle read strobe and word index
//            rd_data         - read data, updated one cycle after rd
//            rd_valid        - one-cycle qualifier for rd_data
//            locked          - high while the timing is stable
// Registers: 0 {29'h0, unstable, timeout, locked}  1 {h_total, h_active}
//            2 {v_total, v_active}  3 {16'h0, frame_count}  4 checksum
//            5 32'h564D4F4E  6..7 zero
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_monitor #(
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic        clk_core_12288,
  input  logic        reset_n,
  input  logic [23:0] video_rgb,
  input  logic        video_de,
  input  logic        video_vs,
  input  logic        video_hs,
  input  logic        rd,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        locked
);

  localparam logic [1:0] c_ST_SEARCH  = 2'd0;
  localparam logic [1:0] c_ST_MEASURE = 2'd1;
  localparam logic [1:0] c_ST_LOCKED  = 2'd2;

  localparam int                c_TO_W      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX    = c_TO_W'(TIMEOUT_CLKS);
  localparam logic [15:0]       c_MATCH_TGT = 16'(LOCK_FRAMES - 1);
  localparam logic [31:0]       c_MAGIC     = 32'h564D4F4E;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic r_vs_prev;
  logic r_hs_prev;
  logic w_vs_edge;
  logic w_hs_edge;

  assign w_vs_edge = video_vs & ~r_vs_prev;
  assign w_hs_edge = video_hs & ~r_hs_prev;

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_prev <= 1'b0;
      r_hs_prev <= 1'b0;
    end else begin
      r_vs_prev <= video_vs;
      r_hs_prev <= video_hs;
    end
  end

  // --------------------------------------------------------------------------
  // No-VS watchdog. Holds at TIMEOUT_CLKS so the timeout fires only once
  // per loss of signal.
  // --------------------------------------------------------------------------
  logic [c_TO_W-1:0] r_novs_cnt;
  logic              w_timeout_hit;

  assign w_timeout_hit = ~w_vs_edge & (r_novs_cnt == c_TO_LAST);

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_novs_cnt <= '0;
    end else if (w_vs_edge) begin
      r_novs_cnt <= '0;
    end else if (r_novs_cnt != c_TO_MAX) begin
      r_novs_cnt <= r_novs_cnt + c_TO_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM state and shared control
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_run;
  logic        w_clear_acc;
  logic        w_unstable_set;

  assign w_run       = (r_state != c_ST_SEARCH);
  // Accumulators are idle in SEARCH until a VS edge starts a frame.
  assign w_clear_acc = w_timeout_hit | (~w_run & ~w_vs_edge);

  // --------------------------------------------------------------------------
  // Running accumulators
  // --------------------------------------------------------------------------
  logic [15:0] r_h_cnt;
  logic [15:0] r_h_act;
  logic [15:0] r_v_cnt;
  logic [15:0] r_v_act;
  logic        r_line_de;
  logic        w_new_de_line;

  // First DE of a line. A line context restarts at an HS edge and also at a
  // VS edge, so DE in the VS cycle is credited to the new frame.
  assign w_new_de_line = video_de & (w_hs_edge | w_vs_edge | ~r_line_de);

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt   <= 16'd0;
      r_h_act   <= 16'd0;
      r_v_cnt   <= 16'd0;
      r_v_act   <= 16'd0;
      r_line_de <= 1'b0;
    end else if (w_clear_acc) begin
      r_h_cnt   <= 16'd0;
      r_h_act   <= 16'd0;
      r_v_cnt   <= 16'd0;
      r_v_act   <= 16'd0;
      r_line_de <= 1'b0;
    end else begin
      // The HS edge cycle is the first clock of the new line.
      if (w_hs_edge) begin
        r_h_cnt <= 16'd1;
        r_h_act <= {15'd0, video_de};
      end else begin
        r_h_cnt <= sat_inc(r_h_cnt);
        if (video_de) r_h_act <= sat_inc(r_h_act);
      end

      if (w_hs_edge || w_vs_edge) r_line_de <= video_de;
      else if (video_de)          r_line_de <= 1'b1;

      // A coincident HS edge is line 1 of the new frame.
      if (w_vs_edge) begin
        r_v_cnt <= {15'd0, w_hs_edge};
        r_v_act <= {15'd0, video_de};
      end else begin
        if (w_hs_edge)     r_v_cnt <= sat_inc(r_v_cnt);
        if (w_new_de_line) r_v_act <= sat_inc(r_v_act);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Latched measurements and frame comparison
  // --------------------------------------------------------------------------
  logic [15:0] r_h_total;
  logic [15:0] r_h_active;
  logic [15:0] r_v_total;
  logic [15:0] r_v_active;
  logic [15:0] r_frame_count;
  logic [15:0] r_match_cnt;
  logic [63:0] r_tuple_prev;
  logic [15:0] w_h_total_nxt;
  logic [15:0] w_h_active_nxt;
  logic [63:0] w_tuple_new;
  logic        w_tuple_eq;
  logic [15:0] w_match_nxt;
  logic        w_frame_end;

  assign w_h_total_nxt  = (w_run && w_hs_edge) ? r_h_cnt : r_h_total;
  assign w_h_active_nxt = (w_run && w_hs_edge && (r_h_act != 16'd0)) ? r_h_act : r_h_active;
  // The tuple includes an HS edge that lands on the VS cycle, since that edge
  // closes the last line of the finishing frame.
  assign w_tuple_new    = {w_h_total_nxt, w_h_active_nxt, r_v_cnt, r_v_act};
  assign w_tuple_eq     = (w_tuple_new == r_tuple_prev);
  assign w_match_nxt    = w_tuple_eq ? sat_inc(r_match_cnt) : 16'd0;
  assign w_frame_end    = w_vs_edge & w_run;

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_h_total     <= 16'd0;
      r_h_active    <= 16'd0;
      r_v_total     <= 16'd0;
      r_v_active    <= 16'd0;
      r_frame_count <= 16'd0;
      r_match_cnt   <= 16'd0;
      r_tuple_prev  <= 64'd0;
    end else if (w_timeout_hit) begin
      r_h_total     <= 16'd0;
      r_h_active    <= 16'd0;
      r_v_total     <= 16'd0;
      r_v_active    <= 16'd0;
      r_frame_count <= 16'd0;
      r_match_cnt   <= 16'd0;
      r_tuple_prev  <= 64'd0;
    end else begin
      r_h_total  <= w_h_total_nxt;
      r_h_active <= w_h_active_nxt;
      if (w_frame_end) begin
        r_v_total     <= r_v_cnt;
        r_v_active    <= r_v_act;
        r_frame_count <= r_frame_count + 16'd1;
        r_match_cnt   <= w_match_nxt;
        r_tuple_prev  <= w_tuple_new;
      end else if (w_vs_edge) begin
        r_match_cnt <= 16'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-frame pixel checksum
  // --------------------------------------------------------------------------
  logic [31:0] w_checksum;

`ifdef VIDEO_MON_CHECKSUM_EN
  logic [31:0] r_sum_acc;
  logic [31:0] r_checksum;

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_acc <= 32'd0;
    end else if (w_clear_acc) begin
      r_sum_acc <= 32'd0;
    end else if (w_vs_edge) begin
      r_sum_acc <= video_de ? {8'h00, video_rgb} : 32'd0;
    end else if (video_de) begin
      r_sum_acc <= r_sum_acc + {8'h00, video_rgb};
    end
  end

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= 32'd0;
    end else if (w_timeout_hit) begin
      r_checksum <= 32'd0;
    end else if (w_frame_end) begin
      r_checksum <= r_sum_acc;
    end
  end

  assign w_checksum = r_checksum;
`else
  logic w_unused_rgb;

  assign w_unused_rgb = ^video_rgb;
  assign w_checksum   = 32'h0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) r_state <= c_ST_SEARCH;
    else          r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout_hit) begin
      w_state_nxt = c_ST_SEARCH;
    end else if (w_vs_edge) begin
      case (r_state)
        c_ST_SEARCH:  w_state_nxt = c_ST_MEASURE;
        c_ST_MEASURE: if (w_match_nxt >= c_MATCH_TGT) w_state_nxt = c_ST_LOCKED;
        c_ST_LOCKED:  if (!w_tuple_eq) w_state_nxt = c_ST_MEASURE;
        default:      w_state_nxt = c_ST_SEARCH;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    locked         = (r_state == c_ST_LOCKED);
    w_unstable_set = w_vs_edge & (r_state == c_ST_LOCKED) & ~w_tuple_eq;
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  logic r_timeout;
  logic r_unstable;

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout  <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      if (w_timeout_hit)  r_timeout <= 1'b1;
      else if (w_vs_edge) r_timeout <= 1'b0;

      // A set in the same cycle as a register-0 read wins.
      if (w_unstable_set)                 r_unstable <= 1'b1;
      else if (rd && (rd_addr == 3'd0))   r_unstable <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Register read port
  // --------------------------------------------------------------------------
  logic [31:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 32'h0;
    case (rd_addr)
      3'd0:    w_rd_mux = {29'h0, r_unstable, r_timeout, locked};
      3'd1:    w_rd_mux = {r_h_total, r_h_active};
      3'd2:    w_rd_mux = {r_v_total, r_v_active};
      3'd3:    w_rd_mux = {16'h0, r_frame_count};
      3'd4:    w_rd_mux = w_checksum;
      3'd5:    w_rd_mux = c_MAGIC;
      default: w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= 32'h0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_monitor
// Purpose  : Self-checking bench for video_timing_monitor using a reduced
//            raster (50 clocks/line, 20 DE clocks from clock 10, 16 lines,
//            active lines 3..12, HS at clock 3, VS at clock 0 of line 0).
//            Expected register reads are queued when issued and checked by
//            a separate monitor whenever rd_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_monitor;

  localparam int LOCK_FRAMES  = 2;
  localparam int TIMEOUT_CLKS = 2000;
  localparam int LINE_CLKS    = 50;
  localparam int FRAME_LINES  = 16;
  localparam int DE_START     = 10;
  localparam int DE_LEN       = 20;
  localparam int ACT_FIRST    = 3;
  localparam int ACT_LAST     = 12;

  // {h_total=50, h_active=20}, {v_total=16, v_active=10}
  localparam logic [31:0] c_REG1  = 32'h0032_0014;
  localparam logic [31:0] c_REG2  = 32'h0010_000A;
  localparam logic [31:0] c_MAGIC = 32'h564D_4F4E;
`ifdef VIDEO_MON_CHECKSUM_EN
  // 10 lines * 20 pixels * 1
  localparam logic [31:0] c_CSUM  = 32'd200;
`else
  localparam logic [31:0] c_CSUM  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] video_rgb = 24'h0;
  logic        video_de = 1'b0;
  logic        video_vs = 1'b0;
  logic        video_hs = 1'b0;
  logic        rd = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        locked;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  addr_q[$];

  always #5 clk = ~clk;

  video_timing_monitor #(
    .LOCK_FRAMES  (LOCK_FRAMES),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk_core_12288 (clk),
    .reset_n        (reset_n),
    .video_rgb      (video_rgb),
    .video_de       (video_de),
    .video_vs       (video_vs),
    .video_hs       (video_hs),
    .rd             (rd),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .locked         (locked)
  );

  // Monitor: every rd_valid consumes one queued expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      logic [31:0] e;
      logic [2:0]  a;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid with no read pending, rd_data=%08h", rd_data);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_reg%0d: got %08h expected %08h", a, rd_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    video_vs  = 1'b0;
    video_hs  = 1'b0;
    video_de  = 1'b0;
    video_rgb = 24'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Emits lines 0..n_lines-1 of a frame; de_len DE clocks per active line.
  task automatic gen_frame(input int de_len, input int n_lines);
    for (int ln = 0; ln < n_lines; ln++) begin
      for (int c = 0; c < LINE_CLKS; c++) begin
        video_vs  = (ln == 0) && (c < 2);
        video_hs  = (c == 3) || (c == 4);
        video_de  = (ln >= ACT_FIRST) && (ln <= ACT_LAST) &&
                    (c >= DE_START) && (c < DE_START + de_len);
        video_rgb = video_de ? 24'h000001 : 24'h000000;
        step();
      end
    end
    idle_inputs();
  endtask

  task automatic rd_push(input logic [2:0] addr, input logic [31:0] exp);
    rd      = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp);
    addr_q.push_back(addr);
    step();
  endtask

  task automatic rd_end();
    rd = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_timeout: %0d reads got no rd_valid, expected 0 pending", exp_q.size());
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (5) step();
    chk("reset_locked",   {31'h0, locked},   32'h0);
    chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("reset_rd_data",  rd_data,           32'h0);
    reset_n = 1'b1;
    repeat (2) step();
    rd_push(3'd0, 32'h0);
    rd_push(3'd5, c_MAGIC);
    rd_push(3'd6, 32'h0);
    rd_end();

    // Stable timing: lock after the third VS
    repeat (3) gen_frame(DE_LEN, FRAME_LINES);
    chk("stable_locked", {31'h0, locked}, 32'h1);
    rd_push(3'd0, 32'h1);
    rd_push(3'd1, c_REG1);
    rd_push(3'd2, c_REG2);
    rd_push(3'd3, 32'd2);
    rd_push(3'd4, c_CSUM);
    rd_push(3'd7, 32'h0);
    rd_end();

    // Instability: one frame with 19 DE per line
    gen_frame(DE_LEN - 1, FRAME_LINES);
    chk("pre_unstable_locked", {31'h0, locked}, 32'h1);
    gen_frame(DE_LEN, FRAME_LINES);
    chk("unstable_locked", {31'h0, locked}, 32'h0);
    rd_push(3'd0, 32'h4);
    rd_push(3'd0, 32'h0);
    rd_push(3'd3, 32'd4);
    rd_end();
    gen_frame(DE_LEN, FRAME_LINES);
    chk("relock_pending", {31'h0, locked}, 32'h0);
    rd_push(3'd0, 32'h0);
    rd_end();
    gen_frame(DE_LEN, FRAME_LINES);
    chk("relock_locked", {31'h0, locked}, 32'h1);
    rd_push(3'd0, 32'h1);
    rd_end();

    // Back-to-back reads 5 then 3
    rd_push(3'd5, c_MAGIC);
    rd_push(3'd3, 32'd6);
    rd_end();

    // Timeout: no VS for longer than TIMEOUT_CLKS
    idle_inputs();
    repeat (TIMEOUT_CLKS + 5) step();
    chk("timeout_locked", {31'h0, locked}, 32'h0);
    rd_push(3'd0, 32'h2);
    rd_push(3'd1, 32'h0);
    rd_push(3'd2, 32'h0);
    rd_push(3'd3, 32'h0);
    rd_push(3'd4, 32'h0);
    rd_end();

    // VS after timeout is in SEARCH: clears timeout, not counted
    gen_frame(DE_LEN, FRAME_LINES);
    rd_push(3'd0, 32'h0);
    rd_push(3'd3, 32'h0);
    rd_end();
    repeat (2) gen_frame(DE_LEN, FRAME_LINES);
    chk("post_timeout_locked", {31'h0, locked}, 32'h1);
    rd_push(3'd1, c_REG1);
    rd_end();

    // Reset in the middle of a frame (start of line 8)
    gen_frame(DE_LEN, 8);
    chk("pre_reset_locked", {31'h0, locked}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midreset_locked",   {31'h0, locked},   32'h0);
    chk("midreset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("midreset_rd_data",  rd_data,           32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();
    rd_push(3'd0, 32'h0);
    rd_push(3'd1, 32'h0);
    rd_push(3'd2, 32'h0);
    rd_push(3'd3, 32'h0);
    rd_end();
    repeat (3) gen_frame(DE_LEN, FRAME_LINES);
    chk("reset_relock_locked", {31'h0, locked}, 32'h1);
    rd_push(3'd1, c_REG1);
    rd_push(3'd2, c_REG2);
    rd_push(3'd3, 32'd2);
    rd_push(3'd4, c_CSUM);
    rd_end();

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/video_timing_monitor.md
VIDEO_TIMING_MONITOR -- requirements
Module: video_timing_monitor

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: the number of consecutive identical frame measurements required to assert lock.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2000000: the number of clocks without a VS edge before no-signal is declared.
REQ-003 SHALL have port clk_core_12288, input, 1 bit: the single clock; all logic runs in this pixel domain.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port video_rgb, input, 24 bits: pixel data.
REQ-006 SHALL have port video_de, input, 1 bit: data enable, marking active pixels.
REQ-007 SHALL have port video_vs, input, 1 bit: vertical sync, a frame-start pulse.
REQ-008 SHALL have port video_hs, input, 1 bit: horizontal sync, a line-start pulse.
REQ-009 SHALL have port rd, input, 1 bit: a one-cycle register read strobe.
REQ-010 SHALL have port rd_addr, input, 3 bits: the register word index.
REQ-011 SHALL have port rd_data, output, 32 bits: the read data.
REQ-012 SHALL have port rd_valid, output, 1 bit: a one-cycle qualifier for rd_data.
REQ-013 SHALL have port locked, output, 1 bit: timing is stable.

Function
REQ-014 SHALL treat a VS edge as any cycle where video_vs=1 and its registered previous value=0; an HS edge SHALL be defined the same way on video_hs.
REQ-015 SHALL count h_total as the clocks from one HS edge to the next HS edge, inclusive of the start cycle; the count SHALL be 16 bits and saturate at 0xFFFF.
REQ-016 SHALL count h_active as the DE-high cycles within a line, latched at the next HS edge only if nonzero; the count SHALL be 16 bits and saturate.
REQ-017 SHALL count v_total as the HS edges per frame and v_active as the lines containing at least one DE cycle; both SHALL be latched at the VS edge, 16 bits, saturating.
REQ-018 SHALL apply these rules when VS and HS edges fall in the same cycle: that HS edge SHALL count as line 1 of the new frame, and DE in that cycle SHALL count toward the new line and new frame.
REQ-019 SHALL count frame_count as VS edges seen outside SEARCH, 16 bits, wrapping 0xFFFF->0.
REQ-020 SHALL implement an FSM with three states: SEARCH, MEASURE, and LOCKED.
REQ-021 SHALL, in SEARCH, discard all accumulation; a VS edge SHALL clear the accumulators and move the FSM to MEASURE.
REQ-022 SHALL, at each VS edge in MEASURE or LOCKED, compare the new {h_total, h_active, v_total, v_active} tuple with the previous tuple: equal increments match_cnt, unequal clears it.
REQ-023 SHALL move MEASURE->LOCKED when match_cnt reaches LOCK_FRAMES-1.
REQ-024 SHALL, on an unequal tuple in LOCKED, move the FSM to MEASURE and set the sticky unstable flag.
REQ-025 SHALL, from any state, move the FSM to SEARCH and set timeout when the no-VS counter reaches TIMEOUT_CLKS; this SHALL also clear all latched measurement registers to 0.
REQ-026 SHALL clear timeout at the next VS edge.
REQ-027 SHALL drive locked=1 if and only if the FSM is in LOCKED.
REQ-028 SHALL make latched values visible the cycle after the edge that latches them.
REQ-029 SHALL answer a read one cycle after rd=1 by driving rd_data and asserting rd_valid=1 for one cycle; rd_data SHALL hold its value otherwise.
REQ-030 SHALL map registers as follows: 0={29'h0, unstable, timeout, locked}; 1={h_total, h_active}; 2={v_total, v_active}; 3={16'h0, frame_count}; 4=checksum; 5=32'h564D4F4E; 6 and 7 read 0.
REQ-031 SHALL clear unstable when register 0 is read; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-032 SHALL accept back-to-back reads every cycle.

Reset
REQ-033 SHALL, while reset_n=0, put the FSM in SEARCH and hold all counters, latched registers, flags, rd_data, rd_valid, and locked at 0.
REQ-034 SHALL abandon an in-progress frame when reset is asserted mid-frame; after release, the next VS edge SHALL start MEASURE.

Configuration
REQ-035 SHALL, with VIDEO_MON_CHECKSUM_EN defined, keep checksum as the 32-bit sum of {8'h00, video_rgb} over all DE cycles of a frame, wrapping modulo 2^32 and latched at the VS edge.
REQ-036 SHALL, without VIDEO_MON_CHECKSUM_EN, synthesise no checksum logic and read register 4 as 32'h0.

Verification
REQ-037 SHALL cover stable timing: 400 clocks/line, DE 320 per line, 512 lines, 288 active lines, HS at clock 3, VS at clock 0 -> after the 3rd VS, reg1=0x01900140, reg2=0x02000120, and locked=1.
REQ-038 SHALL cover the checksum: with VIDEO_MON_CHECKSUM_EN and rgb=0x000001 on all DE cycles -> reg4=0x00016800; without the macro, reg4=0.
REQ-039 SHALL cover instability: change h_active from 320 to 319 on one frame while locked -> locked=0 and reg0=0x4; re-reading reg0 -> 0x0 until relock.
REQ-040 SHALL cover timeout: stop VS for TIMEOUT_CLKS clocks -> state is SEARCH, reg0=0x2, and reg1 through reg4 read 0.
REQ-041 SHALL cover reset mid-frame: assert reset_n=0 at line 100 -> all outputs 0; after release, 3 stable frames -> locked=1.
REQ-042 SHALL cover reads: rd pulses on consecutive cycles to addresses 5 then 3 -> rd_valid high for 2 cycles, with rd_data=0x564D4F4E then frame_count.
